mmr_selector: RTL and testbench
===============================

Name: mmr_selector

Overview:
Address decoder for the memory-mapped register (MMR) window of the CPU address map. It converts a 12-bit bus address into a 7-bit MMR index, relative to base address 1025, plus a hit flag. Index and hit are combinational, so bus logic can select a register in the same cycle. A registered copy (index, hit, one-hot select) is provided for pipelined read-back and peripheral enables.

Parameters:
- ADDR_W, 12, bus address width.
- SEL_W, 7, MMR index width.
- BASE_ADDR, 1025, address of MMR index 0.
- NUM_MMR, 128, number of MMRs in the window; must be ≤ 2^SEL_W.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  bus address.
- sel  out  SEL_W  combinational MMR index.
- hit  out  1  combinational: addr lies in the MMR window.
- sel_q  out  SEL_W  registered sel.
- hit_q  out  1  registered hit.
- sel_oh_q  out  NUM_MMR  registered one-hot select; bit sel_q is set when hit_q=1.

Behaviour:
- Window is BASE_ADDR ≤ addr ≤ BASE_ADDR+NUM_MMR−1. With the default parameters this is 1025..1152.
- hit = 1 when addr is inside the window, else 0. Compare addr as unsigned ADDR_W-bit values.
- sel = (addr − BASE_ADDR), truncated to SEL_W bits, when hit=1.
- sel = 0 when hit=0. A miss is distinguished from index 0 by hit.
- sel and hit are purely combinational: zero latency, no dependence on clk or reset. They settle within one combinational delay of an addr change.
- Registered path, on each rising edge of clk:
  - sel_q ← sel
  - hit_q ← hit
  - sel_oh_q ← (hit ? 1<<sel : 0)
  - Latency is one cycle. No enable; the registers update every cycle.
- Reset: while reset=1, sel_q=0, hit_q=0 and sel_oh_q=all zeros, immediately and without waiting for clk. sel and hit continue to follow addr during reset.
- Reset deasserted: the first rising edge after deassertion captures the current addr decode.
- Reset asserted mid-stream: the registered outputs clear at once and hold zero until the first edge after release.
- sel_oh_q is always one-hot or all-zero, never multi-hot.
- Boundaries (default parameters):
  - addr=1024 → miss.
  - addr=1025 → hit, sel=0.
  - addr=1152 → hit, sel=127.
  - addr=1153 → miss.
  - addr=0 and addr=4095 → miss.
  - No wrap-around: addresses above the window never alias into it.

Test Plan:
- Sweep addr = 1025..1099, holding each value 10 ns and without toggling clk → sel == addr−1025 and hit=1 at every step (sel 0..74).
- Window edges: addr = 1024, 1025, 1152, 1153 → (hit, sel) = (0,0), (1,0), (1,127), (0,0).
- Extremes: addr = 0 and addr = 4095 → hit=0, sel=0.
- Registered path: apply addr=1030, then one clk edge → sel_q=5, hit_q=1, sel_oh_q has only bit 5 set. Then apply addr=2000 and one edge → hit_q=0, sel_oh_q=0.
- Async reset: with hit_q=1, assert reset between clock edges → sel_q, hit_q and sel_oh_q are 0 immediately, while sel and hit still track addr. Deassert reset → the next edge captures the current decode.
- Full window sweep with a clock, addr 1025..1152 → each cycle sel_q equals the previous cycle's addr−1025, and popcount(sel_oh_q)=1.

Source files
------------

// File: rtl/mmr_selector.sv
// Decodes a bus address into an index within the memory-mapped register window.
// Index and hit are combinational; a registered copy adds a one-hot select.
module mmr_selector #(
  parameter int ADDR_W    = 12,
  parameter int SEL_W     = 7,
  parameter int BASE_ADDR = 1025,
  parameter int NUM_MMR   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  addr,
  output logic [SEL_W-1:0]   sel,
  output logic               hit,
  output logic [SEL_W-1:0]   sel_q,
  output logic               hit_q,
  output logic [NUM_MMR-1:0] sel_oh_q
);

  localparam int unsigned    WIN_LO  = BASE_ADDR;
  localparam int unsigned    WIN_HI  = BASE_ADDR + NUM_MMR - 1;
  localparam logic [SEL_W-1:0] BASE_LO = SEL_W'(BASE_ADDR);

  logic [31:0]        addr_ext;
  logic [SEL_W-1:0]   offset;
  logic [NUM_MMR-1:0] oh_d;

  // Compare in 32 bits so the window bound can never wrap within ADDR_W.
  assign addr_ext = {{(32-ADDR_W){1'b0}}, addr};
  assign hit      = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);

  // Modular subtraction on the low bits equals the truncated full difference.
  assign offset = addr[SEL_W-1:0] - BASE_LO;
  assign sel    = hit ? offset : '0;

  for (genvar g = 0; g < NUM_MMR; g++) begin : g_oh
    assign oh_d[g] = hit && (sel == SEL_W'(g));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      hit_q    <= 1'b0;
      sel_oh_q <= '0;
    end else begin
      sel_q    <= sel;
      hit_q    <= hit;
      sel_oh_q <= oh_d;
    end
  end

endmodule

// File: tb/tb_mmr_selector.sv
// Self-checking bench for mmr_selector: vector table, directed sequences and
// random addresses checked against an arithmetic reference model.
module tb_mmr_selector;

  localparam int ADDR_W = 12;
  localparam int SEL_W  = 7;
  localparam int BASE   = 1025;
  localparam int NMMR   = 128;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic              hit;
  logic [SEL_W-1:0]  sel_q;
  logic              hit_q;
  logic [NMMR-1:0]   sel_oh_q;

  int vectors;
  int miscompares;

  mmr_selector #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .BASE_ADDR(BASE), .NUM_MMR(NMMR)) dut (
    .clk(clk), .reset(reset), .addr(addr), .sel(sel), .hit(hit),
    .sel_q(sel_q), .hit_q(hit_q), .sel_oh_q(sel_oh_q)
  );

  typedef struct {
    int a;
    int exp_hit;
    int exp_sel;
  } vec_t;

  // Reference: window test and index from plain integer arithmetic.
  function automatic int ref_hit(input int a);
    return (a >= BASE && a <= BASE + NMMR - 1) ? 1 : 0;
  endfunction

  function automatic int ref_sel(input int a);
    return ref_hit(a) ? (a - BASE) : 0;
  endfunction

  function automatic logic [NMMR-1:0] ref_oh(input int a);
    logic [NMMR-1:0] v;
    v = '0;
    if (ref_hit(a)) v[a - BASE] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [NMMR-1:0] act, input logic [NMMR-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string name, input int a);
    check({name, " hit"}, NMMR'(hit), NMMR'(ref_hit(a)));
    check({name, " sel"}, NMMR'(sel), NMMR'(ref_sel(a)));
  endtask

  task automatic check_regs(input string name, input int a);
    check({name, " hit_q"}, NMMR'(hit_q), NMMR'(ref_hit(a)));
    check({name, " sel_q"}, NMMR'(sel_q), NMMR'(ref_sel(a)));
    check({name, " sel_oh_q"}, sel_oh_q, ref_oh(a));
    check({name, " onehot"}, NMMR'($countones(sel_oh_q)), NMMR'(ref_hit(a)));
  endtask

  task automatic tick();
    clk = 1'b1; #5;
    clk = 1'b0; #5;
  endtask

  vec_t tbl[$];

  initial begin
    int a;
    vectors = 0;
    miscompares = 0;
    clk = 1'b0;
    reset = 1'b1;
    addr = '0;

    tbl.push_back('{1024, 0, 0});
    tbl.push_back('{1025, 1, 0});
    tbl.push_back('{1152, 1, 127});
    tbl.push_back('{1153, 0, 0});
    tbl.push_back('{0,    0, 0});
    tbl.push_back('{4095, 0, 0});
    tbl.push_back('{1089, 1, 64});
    tbl.push_back('{3073, 0, 0});

    // Reset state, no clock needed.
    #1;
    check("reset sel_q", NMMR'(sel_q), '0);
    check("reset hit_q", NMMR'(hit_q), '0);
    check("reset sel_oh_q", sel_oh_q, '0);
    reset = 1'b0;

    // Table of boundary/extreme vectors, combinational only.
    foreach (tbl[i]) begin
      addr = ADDR_W'(tbl[i].a);
      #10;
      check($sformatf("tbl%0d hit", i), NMMR'(hit), NMMR'(tbl[i].exp_hit));
      check($sformatf("tbl%0d sel", i), NMMR'(sel), NMMR'(tbl[i].exp_sel));
    end

    // Unclocked sweep inside the window.
    for (int x = 1025; x <= 1099; x++) begin
      addr = ADDR_W'(x);
      #10;
      check_comb($sformatf("sweep %0d", x), x);
    end

    // Registered path, hit then miss.
    addr = ADDR_W'(1030);
    tick();
    check("reg1030 sel_q", NMMR'(sel_q), NMMR'(5));
    check("reg1030 hit_q", NMMR'(hit_q), NMMR'(1));
    check("reg1030 sel_oh_q", sel_oh_q, NMMR'(1) << 5);
    addr = ADDR_W'(2000);
    tick();
    check("reg2000 hit_q", NMMR'(hit_q), '0);
    check("reg2000 sel_oh_q", sel_oh_q, '0);

    // Async reset between edges.
    addr = ADDR_W'(1030);
    tick();
    check_regs("prerst", 1030);
    #2 reset = 1'b1;
    #1;
    check("arst sel_q", NMMR'(sel_q), '0);
    check("arst hit_q", NMMR'(hit_q), '0);
    check("arst sel_oh_q", sel_oh_q, '0);
    addr = ADDR_W'(1100);
    #1;
    check_comb("arst comb", 1100);
    tick();
    check("arst held hit_q", NMMR'(hit_q), '0);
    check("arst held sel_oh_q", sel_oh_q, '0);
    reset = 1'b0;
    #1;
    check("rel hit_q", NMMR'(hit_q), '0);
    tick();
    check_regs("rel edge", 1100);

    // Clocked full-window sweep.
    for (int x = 1025; x <= 1152; x++) begin
      addr = ADDR_W'(x);
      tick();
      check_regs($sformatf("wsweep %0d", x), x);
    end

    // Random addresses, biased toward the window edges.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(1, 0) == 1) a = int'($urandom_range(1200, 1000));
      else a = int'($urandom_range(4095, 0));
      addr = ADDR_W'(a);
      #1;
      check_comb($sformatf("rnd%0d", n), a);
      #4;
      tick();
      check_regs($sformatf("rnd%0d", n), a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
